// File: rtl/sprite_linebuf_writer.sv
// Sprite line-buffer writer: fetches 8-pixel 4bpp sprite rows and draws them into a
// double-buffered 256-entry line buffer. Define SPRITE_LIMIT_EN to cap fetches per line at MAX_SPR.
module sprite_linebuf_writer #(
    parameter int MAX_SPR = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        line_swap,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_ocs_n,
    input  logic [5:0]  cmd_row,
    input  logic [7:0]  cmd_code,
    input  logic [7:0]  cmd_x,
    input  logic [3:0]  cmd_color,
    input  logic        cmd_flipx,
    output logic [13:0] rom_addr,
    output logic        rom_req,
    input  logic        rom_ack,
    input  logic [31:0] rom_data,
    input  logic        rd_en,
    input  logic [7:0]  rd_x,
    output logic [7:0]  pix,
    output logic        overrun
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAW} state_e;

    state_e      state_q, state_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        rom_req_q, rom_req_d;
    logic [13:0] rom_addr_q, rom_addr_d;
    logic [7:0]  x_q, x_d;
    logic [3:0]  color_q, color_d;
    logic        flip_q, flip_d;
    logic [31:0] data_q, data_d;
    logic [2:0]  n_q, n_d;
    logic        wbank_q, wbank_d;
    logic        overrun_q, overrun_d;
    logic [7:0]  pix_q, pix_d;
    logic        limit_hit;

    logic [7:0]  linebuf [2][256];

    logic [3:0]  src_pix;
    logic [8:0]  wr_addr9;
    logic        draw_we;

`ifdef SPRITE_LIMIT_EN
    localparam int CNT_W = $clog2(MAX_SPR + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign limit_hit = (cnt_q >= CNT_W'(MAX_SPR));
`else
    assign limit_hit = 1'b0;
`endif

    // Flipped rows walk the fetched word from pixel 7 down; 7-n is simply ~n for 3 bits.
    always_comb begin
        src_pix  = flip_q ? data_q[{~n_q, 2'b00} +: 4] : data_q[{n_q, 2'b00} +: 4];
        wr_addr9 = {1'b0, x_q} + {6'd0, n_q};
        draw_we  = (state_q == DRAW) && !line_swap && (src_pix != 4'd0)
                   && !wr_addr9[8] && (linebuf[wbank_q][wr_addr9[7:0]] == 8'd0);
    end

    always_comb begin
        // NOTE: every target gets a default first so no path through the case leaves a latch.
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        rom_req_d   = rom_req_q;
        rom_addr_d  = rom_addr_q;
        x_d         = x_q;
        color_d     = color_q;
        flip_d      = flip_q;
        data_d      = data_q;
        n_d         = n_q;
        wbank_d     = wbank_q;
        overrun_d   = overrun_q;
        pix_d       = rd_en ? linebuf[~wbank_q][rd_x] : pix_q;
`ifdef SPRITE_LIMIT_EN
        cnt_d       = cnt_q;
`endif

        if (line_swap) begin
            wbank_d = ~wbank_q;
`ifdef SPRITE_LIMIT_EN
            cnt_d   = '0;
`endif
            if (state_q != IDLE) begin
                state_d     = IDLE;
                rom_req_d   = 1'b0;
                cmd_ready_d = 1'b1;
                overrun_d   = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid && cmd_ready_q && !cmd_ocs_n && !limit_hit) begin
                        state_d     = FETCH;
                        x_d         = cmd_x;
                        color_d     = cmd_color;
                        flip_d      = cmd_flipx;
                        rom_addr_d  = {cmd_code, cmd_row};
                        rom_req_d   = 1'b1;
                        cmd_ready_d = 1'b0;
`ifdef SPRITE_LIMIT_EN
                        cnt_d       = cnt_q + 1'b1;
`endif
                    end
                end
                FETCH: begin
                    if (rom_ack) begin
                        state_d   = DRAW;
                        data_d    = rom_data;
                        rom_req_d = 1'b0;
                        n_d       = 3'd0;
                    end
                end
                DRAW: begin
                    n_d = n_q + 3'd1;
                    if (n_q == 3'd7) begin
                        state_d     = IDLE;
                        cmd_ready_d = 1'b1;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    cmd_ready_d = 1'b1;
                    rom_req_d   = 1'b0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            rom_req_q   <= 1'b0;
            rom_addr_q  <= '0;
            x_q         <= '0;
            color_q     <= '0;
            flip_q      <= 1'b0;
            data_q      <= '0;
            n_q         <= '0;
            wbank_q     <= 1'b0;
            overrun_q   <= 1'b0;
            pix_q       <= '0;
`ifdef SPRITE_LIMIT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rom_req_q   <= rom_req_d;
            rom_addr_q  <= rom_addr_d;
            x_q         <= x_d;
            color_q     <= color_d;
            flip_q      <= flip_d;
            data_q      <= data_d;
            n_q         <= n_d;
            wbank_q     <= wbank_d;
            overrun_q   <= overrun_d;
            pix_q       <= pix_d;
`ifdef SPRITE_LIMIT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    // NOTE: the line buffer has no reset so it maps onto RAM; the video-side read-clear empties it.
    always_ff @(posedge clk) begin
        if (draw_we) linebuf[wbank_q][wr_addr9[7:0]] <= {color_q, src_pix};
        if (rd_en)   linebuf[~wbank_q][rd_x] <= 8'd0;
    end

    assign cmd_ready = cmd_ready_q;
    assign rom_req   = rom_req_q;
    assign rom_addr  = rom_addr_q;
    assign pix       = pix_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_sprite_linebuf_writer.sv
// Directed bench for sprite_linebuf_writer: draw, flip, clip, priority, abort and reset cases.
module tb_sprite_linebuf_writer;

`ifdef SPRITE_LIMIT_EN
    localparam int TB_MAX_SPR = 2;
`else
    localparam int TB_MAX_SPR = 24;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        line_swap = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_ocs_n = 1'b1;
    logic [5:0]  cmd_row = '0;
    logic [7:0]  cmd_code = '0;
    logic [7:0]  cmd_x = '0;
    logic [3:0]  cmd_color = '0;
    logic        cmd_flipx = 1'b0;
    logic [13:0] rom_addr;
    logic        rom_req;
    logic        rom_ack = 1'b0;
    logic [31:0] rom_data = '0;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_x = '0;
    logic [7:0]  pix;
    logic        overrun;

    int n_cmp = 0;
    int n_err = 0;

    sprite_linebuf_writer #(.MAX_SPR(TB_MAX_SPR)) dut (
        .clk(clk), .reset(reset), .line_swap(line_swap),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ocs_n(cmd_ocs_n),
        .cmd_row(cmd_row), .cmd_code(cmd_code), .cmd_x(cmd_x),
        .cmd_color(cmd_color), .cmd_flipx(cmd_flipx),
        .rom_addr(rom_addr), .rom_req(rom_req), .rom_ack(rom_ack), .rom_data(rom_data),
        .rd_en(rd_en), .rd_x(rd_x), .pix(pix), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int cyc = 0;
        while (!cmd_ready && cyc < 50) begin
            tick();
            cyc++;
        end
        if (!cmd_ready) check("ready_timeout", {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic send_cmd(input logic ocs_n, input logic [5:0] row, input logic [7:0] code,
                            input logic [7:0] x, input logic [3:0] color, input logic flip);
        cmd_ocs_n = ocs_n; cmd_row = row; cmd_code = code;
        cmd_x = x; cmd_color = color; cmd_flipx = flip;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic ack_row(input logic [31:0] data);
        tick();
        rom_ack = 1'b1; rom_data = data;
        tick();
        rom_ack = 1'b0;
    endtask

    task automatic draw(input string tag, input logic [7:0] x, input logic [3:0] color,
                        input logic [7:0] code, input logic [5:0] row, input logic flip,
                        input logic [31:0] data, input logic [13:0] exp_addr);
        wait_ready();
        send_cmd(1'b0, row, code, x, color, flip);
        check({tag, "_req"}, {31'd0, rom_req}, 32'd1);
        check({tag, "_addr"}, {18'd0, rom_addr}, {18'd0, exp_addr});
        ack_row(data);
        wait_ready();
    endtask

    task automatic read_pix(input logic [7:0] x, output logic [7:0] val);
        rd_en = 1'b1; rd_x = x;
        tick();
        rd_en = 1'b0;
        val = pix;
    endtask

    logic [7:0] flip_exp [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h7F, 8'h00, 8'h71};
    logic [7:0] edge_exp [6] = '{8'h51, 8'h51, 8'h21, 8'h21, 8'h21, 8'h21};

    initial begin
        logic [7:0] v;
        int fetches;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_req", {31'd0, rom_req}, 32'd0);
        check("rst_addr", {18'd0, rom_addr}, 32'd0);
        check("rst_pix", {24'd0, pix}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);

        // Both banks start undefined: read-clear the display bank, swap, clear the other, swap back.
        for (int b = 0; b < 2; b++) begin
            rd_en = 1'b1;
            for (int i = 0; i < 256; i++) begin
                rd_x = 8'(i);
                tick();
            end
            rd_en = 1'b0;
            line_swap = 1'b1;
            tick();
            line_swap = 1'b0;
        end

        draw("basic", 8'd16, 4'd3, 8'h12, 6'd5, 1'b0, 32'h8765_4321, 14'h0485);
        draw("flip", 8'd100, 4'd7, 8'h01, 6'd2, 1'b1, 32'h0000_0F01, 14'h0042);
        draw("edge", 8'd252, 4'd2, 8'hA0, 6'd0, 1'b0, 32'h1111_1111, 14'h2800);
        draw("over", 8'd250, 4'd5, 8'hA0, 6'd1, 1'b0, 32'h1111_1111, 14'h2801);

        send_cmd(1'b1, 6'd3, 8'h44, 8'd40, 4'd9, 1'b0);
        check("skip_req", {31'd0, rom_req}, 32'd0);
        check("skip_ready", {31'd0, cmd_ready}, 32'd1);

        line_swap = 1'b1;
        tick();
        line_swap = 1'b0;

        for (int i = 0; i < 8; i++) begin
            read_pix(8'(16 + i), v);
            check($sformatf("basic_x%0d", 16 + i), {24'd0, v}, 32'h31 + 32'(i));
        end
        read_pix(8'd16, v);
        check("basic_cleared", {24'd0, v}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            read_pix(8'(100 + i), v);
            check($sformatf("flip_x%0d", 100 + i), {24'd0, v}, {24'd0, flip_exp[i]});
        end
        read_pix(8'd40, v);
        check("skip_x40", {24'd0, v}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            read_pix(8'(i), v);
            check($sformatf("nowrap_x%0d", i), {24'd0, v}, 32'd0);
        end
        for (int i = 0; i < 6; i++) begin
            read_pix(8'(250 + i), v);
            check($sformatf("edge_x%0d", 250 + i), {24'd0, v}, {24'd0, edge_exp[i]});
        end

        // Abort a fetch with line_swap while a new command is also offered.
        send_cmd(1'b0, 6'd0, 8'h33, 8'd8, 4'd1, 1'b0);
        check("abort_req_before", {31'd0, rom_req}, 32'd1);
        line_swap = 1'b1; cmd_valid = 1'b1; cmd_ocs_n = 1'b0;
        tick();
        line_swap = 1'b0; cmd_valid = 1'b0;
        check("abort_req", {31'd0, rom_req}, 32'd0);
        check("abort_overrun", {31'd0, overrun}, 32'd1);
        check("abort_ready", {31'd0, cmd_ready}, 32'd1);
        tick();
        check("abort_no_accept", {31'd0, rom_req}, 32'd0);

        // line_swap wins over an accept in IDLE.
        line_swap = 1'b1; cmd_valid = 1'b1; cmd_ocs_n = 1'b0;
        tick();
        line_swap = 1'b0; cmd_valid = 1'b0;
        check("swap_prio_req", {31'd0, rom_req}, 32'd0);
        check("swap_prio_ready", {31'd0, cmd_ready}, 32'd1);
        check("overrun_sticky", {31'd0, overrun}, 32'd1);

`ifdef SPRITE_LIMIT_EN
        fetches = 0;
        for (int i = 0; i < 3; i++) begin
            wait_ready();
            send_cmd(1'b0, 6'd0, 8'(i), 8'(i * 8), 4'd1, 1'b0);
            if (rom_req) begin
                fetches++;
                ack_row(32'h0);
                wait_ready();
            end
        end
        check("limit_fetches", 32'(fetches), 32'd2);
        line_swap = 1'b1;
        tick();
        line_swap = 1'b0;
        send_cmd(1'b0, 6'd0, 8'h09, 8'd0, 4'd1, 1'b0);
        check("limit_restart", {31'd0, rom_req}, 32'd1);
        ack_row(32'h0);
        wait_ready();
`else
        fetches = 0;
`endif

        // Asynchronous reset in the middle of DRAW.
        read_pix(8'd255, v);
        send_cmd(1'b0, 6'd7, 8'h55, 8'd60, 4'd6, 1'b0);
        ack_row(32'hFFFF_FFFF);
        tick(); tick();
        reset = 1'b1;
        #1;
        check("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("mid_rst_req", {31'd0, rom_req}, 32'd0);
        check("mid_rst_addr", {18'd0, rom_addr}, 32'd0);
        check("mid_rst_pix", {24'd0, pix}, 32'd0);
        check("mid_rst_overrun", {31'd0, overrun}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
